// File: rtl/uart_pkg.sv
// Shared types and helpers for the flow-controlled UART host interface.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_ODD = 2'd1, PAR_EVEN = 2'd2} parity_e;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

    localparam int DEF_CLK_RATE  = 100_000_000;
    localparam int DEF_BAUD_RATE = 115200;
    localparam int CLKS_PER_BIT  = DEF_CLK_RATE / DEF_BAUD_RATE;

    function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
        return clk_rate / baud_rate;
    endfunction

    // Unused upper data bits must be zero so they do not disturb the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input parity_e mode);
        case (mode)
            PAR_ODD:  return ~(^data);
            PAR_EVEN: return ^data;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with fill level; head reads 0 when empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     WE_I,
    input  logic [WIDTH-1:0]         DIN_I,
    input  logic                     RE_I,
    output logic [WIDTH-1:0]         DOUT_O,
    output logic                     EMPTY_O,
    output logic                     FULL_O,
    output logic [$clog2(DEPTH):0]   LEVEL_O
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    // A write into a full FIFO is allowed when a read frees the slot in the same cycle.
    assign do_rd   = RE_I && !EMPTY_O;
    assign do_wr   = WE_I && (!FULL_O || RE_I);
    assign EMPTY_O = (LEVEL_O == '0);
    assign FULL_O  = (LEVEL_O == LVL_FULL);
    assign DOUT_O  = EMPTY_O ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            LEVEL_O <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   LEVEL_O <= LEVEL_O + 1'b1;
                2'b01:   LEVEL_O <= LEVEL_O - 1'b1;
                default: LEVEL_O <= LEVEL_O;
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (do_wr) mem[wr_ptr] <= DIN_I;
    end

endmodule

// File: rtl/uart_fc_if.sv
// UART host interface: configurable frame, RX/TX FIFOs, RTS/CTS flow control, sticky errors.
module uart_fc_if
    import uart_pkg::*;
#(
    parameter int CLK_RATE      = 100_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int FIFO_DEPTH    = 16,
    parameter int RTS_THRESHOLD = FIFO_DEPTH - 2
) (
    input  logic                          CLK_I,
    input  logic                          RST_I,
    input  logic                          WE_I,
    input  logic [DATA_BITS-1:0]          DSEND_I,
    output logic                          TX_READY_O,
    output logic [$clog2(FIFO_DEPTH):0]   TX_LEVEL_O,
    input  logic                          RE_I,
    output logic [DATA_BITS-1:0]          DREC_O,
    output logic                          RX_VALID_O,
    output logic                          RX_FULL_O,
    output logic [$clog2(FIFO_DEPTH):0]   RX_LEVEL_O,
    input  logic                          RX_I,
    output logic                          TX_O,
    input  logic                          CTS_NI,
    output logic                          RTS_NO,
    output logic                          PARITY_ERR_O,
    output logic                          FRAME_ERR_O,
    output logic                          OVERRUN_O,
    input  logic                          ERR_CLR_I
);
    localparam int          CPB      = clks_per_bit(CLK_RATE, BAUD_RATE);
    localparam int          LW       = $clog2(FIFO_DEPTH) + 1;
    localparam parity_e     PMODE    = parity_e'(PARITY);
    localparam logic        HAS_PAR  = (PMODE != PAR_NONE);
    localparam logic [15:0] BIT_END  = 16'(CPB - 1);
    localparam logic [15:0] HALF_END = 16'(CPB / 2 - 1);
    localparam logic [15:0] STOP_END = 16'(STOP_BITS * CPB - 1);
    localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

    localparam logic [2:0] TXS_IDLE = TX_IDLE,  TXS_START = TX_START, TXS_DATA = TX_DATA;
    localparam logic [2:0] TXS_PAR  = TX_PARITY, TXS_STOP = TX_STOP;
    localparam logic [2:0] RXS_IDLE = RX_IDLE,  RXS_START = RX_START, RXS_DATA = RX_DATA;
    localparam logic [2:0] RXS_PAR  = RX_PARITY, RXS_STOP = RX_STOP;

    logic [1:0] rx_sync, cts_sync;
    logic       rx_s, rx_q, cts_s;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rx_sync  <= 2'b11;
            cts_sync <= 2'b11;
            rx_q     <= 1'b1;
        end else begin
            rx_sync  <= {rx_sync[0], RX_I};
            cts_sync <= {cts_sync[0], CTS_NI};
            rx_q     <= rx_s;
        end
    end
    assign rx_s  = rx_sync[1];
    assign cts_s = cts_sync[1];

    logic                 tx_push, tx_pop, tx_empty, tx_full;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_push, rx_empty;

    assign tx_push    = WE_I && !tx_full;
    assign TX_READY_O = !tx_full;
    assign RX_VALID_O = !rx_empty;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .CLK_I(CLK_I), .RST_I(RST_I), .WE_I(tx_push), .DIN_I(DSEND_I), .RE_I(tx_pop),
        .DOUT_O(tx_head), .EMPTY_O(tx_empty), .FULL_O(tx_full), .LEVEL_O(TX_LEVEL_O)
    );

    logic [DATA_BITS-1:0] rx_shift;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .CLK_I(CLK_I), .RST_I(RST_I), .WE_I(rx_push), .DIN_I(rx_shift), .RE_I(RE_I),
        .DOUT_O(DREC_O), .EMPTY_O(rx_empty), .FULL_O(RX_FULL_O), .LEVEL_O(RX_LEVEL_O)
    );

    // ---------------- transmitter ----------------
    logic [2:0]           tx_state;
    logic [15:0]          tx_cnt;
    logic [3:0]           tx_bit;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_par;

    assign tx_pop = (tx_state == TXS_IDLE) && !tx_empty && !cts_s;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            tx_state <= TXS_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            TX_O     <= 1'b1;
        end else begin
            case (tx_state)
                TXS_IDLE: if (tx_pop) begin
                    tx_state <= TXS_START;
                    tx_cnt   <= '0;
                    tx_shift <= tx_head;
                    tx_par   <= parity_bit(9'(tx_head), PMODE);
                    TX_O     <= 1'b0;
                end
                TXS_START: if (tx_cnt == BIT_END) begin
                    tx_cnt   <= '0;
                    tx_bit   <= '0;
                    tx_state <= TXS_DATA;
                    TX_O     <= tx_shift[0];
                end else tx_cnt <= tx_cnt + 16'd1;
                TXS_DATA: if (tx_cnt == BIT_END) begin
                    tx_cnt <= '0;
                    if (tx_bit == LAST_BIT) begin
                        tx_state <= HAS_PAR ? TXS_PAR : TXS_STOP;
                        TX_O     <= HAS_PAR ? tx_par : 1'b1;
                    end else begin
                        tx_bit   <= tx_bit + 4'd1;
                        tx_shift <= tx_shift >> 1;
                        TX_O     <= tx_shift[1];
                    end
                end else tx_cnt <= tx_cnt + 16'd1;
                TXS_PAR: if (tx_cnt == BIT_END) begin
                    tx_cnt   <= '0;
                    tx_state <= TXS_STOP;
                    TX_O     <= 1'b1;
                end else tx_cnt <= tx_cnt + 16'd1;
                TXS_STOP: if (tx_cnt == STOP_END) begin
                    tx_cnt   <= '0;
                    tx_state <= TXS_IDLE;
                end else tx_cnt <= tx_cnt + 16'd1;
                default: tx_state <= TXS_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic [2:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [3:0]  rx_bit;
    logic        rx_par;
    logic        stop_pt, frame_bad, par_bad, rx_good;

    // Everything is decided at the first stop-bit centre; extra stop bits are not checked.
    assign stop_pt   = (rx_state == RXS_STOP) && (rx_cnt == BIT_END);
    assign frame_bad = stop_pt && !rx_s;
    assign par_bad   = stop_pt && rx_s && HAS_PAR && (rx_par != parity_bit(9'(rx_shift), PMODE));
    assign rx_good   = stop_pt && rx_s && !par_bad;
    assign rx_push   = rx_good && !RX_FULL_O;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rx_state <= RXS_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
        end else begin
            case (rx_state)
                RXS_IDLE: if (rx_q && !rx_s) begin
                    rx_state <= RXS_START;
                    rx_cnt   <= '0;
                end
                RXS_START: if (rx_cnt == HALF_END) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s ? RXS_IDLE : RXS_DATA;
                end else rx_cnt <= rx_cnt + 16'd1;
                RXS_DATA: if (rx_cnt == BIT_END) begin
                    rx_cnt   <= '0;
                    rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                    if (rx_bit == LAST_BIT) rx_state <= HAS_PAR ? RXS_PAR : RXS_STOP;
                    else                    rx_bit   <= rx_bit + 4'd1;
                end else rx_cnt <= rx_cnt + 16'd1;
                RXS_PAR: if (rx_cnt == BIT_END) begin
                    rx_cnt   <= '0;
                    rx_par   <= rx_s;
                    rx_state <= RXS_STOP;
                end else rx_cnt <= rx_cnt + 16'd1;
                RXS_STOP: if (rx_cnt == BIT_END) begin
                    rx_cnt   <= '0;
                    rx_state <= RXS_IDLE;
                end else rx_cnt <= rx_cnt + 16'd1;
                default: rx_state <= RXS_IDLE;
            endcase
        end
    end

    // Sticky flags: a new error beats a simultaneous clear.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            PARITY_ERR_O <= 1'b0;
            FRAME_ERR_O  <= 1'b0;
            OVERRUN_O    <= 1'b0;
            RTS_NO       <= 1'b0;
        end else begin
            PARITY_ERR_O <= par_bad   || (PARITY_ERR_O && !ERR_CLR_I);
            FRAME_ERR_O  <= frame_bad || (FRAME_ERR_O  && !ERR_CLR_I);
            OVERRUN_O    <= (rx_good && RX_FULL_O) || (OVERRUN_O && !ERR_CLR_I);
            RTS_NO       <= (RX_LEVEL_O >= LW'(RTS_THRESHOLD));
        end
    end

endmodule

// File: tb/tb_uart_fc_if.sv
// Scoreboard bench for uart_fc_if: 10 clk/bit, 8 data bits, even parity, 4-deep FIFOs.
module tb_uart_fc_if;
    localparam int CPB   = 10;
    localparam int DEPTH = 4;
    localparam int NBITS = 11;

    logic       CLK_I = 1'b0, RST_I = 1'b1, WE_I = 1'b0, RE_I = 1'b0, ERR_CLR_I = 1'b0, CTS_NI = 1'b0;
    logic [7:0] DSEND_I = '0;
    logic       RX_I;
    logic       TX_READY_O, RX_VALID_O, RX_FULL_O, TX_O, RTS_NO, PARITY_ERR_O, FRAME_ERR_O, OVERRUN_O;
    logic [2:0] TX_LEVEL_O, RX_LEVEL_O;
    logic [7:0] DREC_O;

    logic loop = 1'b1, inj = 1'b1;
    assign RX_I = loop ? TX_O : inj;

    uart_fc_if #(.CLK_RATE(100_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .RTS_THRESHOLD(3)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .WE_I(WE_I), .DSEND_I(DSEND_I), .TX_READY_O(TX_READY_O),
        .TX_LEVEL_O(TX_LEVEL_O), .RE_I(RE_I), .DREC_O(DREC_O), .RX_VALID_O(RX_VALID_O),
        .RX_FULL_O(RX_FULL_O), .RX_LEVEL_O(RX_LEVEL_O), .RX_I(RX_I), .TX_O(TX_O), .CTS_NI(CTS_NI),
        .RTS_NO(RTS_NO), .PARITY_ERR_O(PARITY_ERR_O), .FRAME_ERR_O(FRAME_ERR_O),
        .OVERRUN_O(OVERRUN_O), .ERR_CLR_I(ERR_CLR_I)
    );

    always #5 CLK_I = ~CLK_I;

    int n_chk = 0, n_fail = 0, cyc = 0;
    logic [7:0]  rx_q[$];
    logic [10:0] tx_q[$];
    bit auto_read = 0, tx_mon_en = 1, trk_arm = 0;
    int t_lvl3, t_rts;

    always @(posedge CLK_I) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference frame: start 0, data LSB first, even-parity bit, one stop bit.
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2) == 1;
        return {1'b1, p, d, 1'b0};
    endfunction

    // RX monitor: pop and compare whenever a word is offered and reading is enabled.
    always @(negedge CLK_I) begin
        if (auto_read && RX_VALID_O && !RST_I) begin
            if (rx_q.size() == 0) chk("rx_unexpected", int'(DREC_O), -1);
            else                  chk("rx_word", int'(DREC_O), int'(rx_q.pop_front()));
            RE_I = 1'b1;
        end else begin
            RE_I = 1'b0;
        end
    end

    // TX monitor: sample each bit at its centre once a start edge is seen.
    initial begin : txmon
        logic prev;
        logic [10:0] got;
        prev = 1'b1;
        forever begin
            @(negedge CLK_I);
            if (tx_mon_en && !RST_I && prev && !TX_O) begin
                repeat (CPB / 2) @(negedge CLK_I);
                got[0] = TX_O;
                for (int i = 1; i < NBITS; i++) begin
                    repeat (CPB) @(negedge CLK_I);
                    got[i] = TX_O;
                end
                if (tx_q.size() == 0) chk("tx_unexpected", int'(got), -1);
                else                  chk("tx_frame", int'(got), int'(tx_q.pop_front()));
            end
            prev = TX_O;
        end
    end

    // Records when RX level first reaches 3 and when RTS_NO first rises.
    always @(negedge CLK_I) begin : trk
        logic [2:0] pl;
        logic       pr;
        if (!trk_arm) begin
            t_lvl3 = -1;
            t_rts  = -1;
        end else begin
            if (RX_LEVEL_O == 3'd3 && pl != 3'd3 && t_lvl3 < 0) t_lvl3 = cyc;
            if (RTS_NO && !pr && t_rts < 0) t_rts = cyc;
        end
        pl = RX_LEVEL_O;
        pr = RTS_NO;
    end

    task automatic send(input logic [7:0] d, input bit expect_it);
        int n = 0;
        @(negedge CLK_I);
        while (!TX_READY_O && n < 2000) begin @(negedge CLK_I); n++; end
        if (n >= 2000) chk("tx_ready_timeout", n, -1);
        WE_I = 1'b1; DSEND_I = d;
        if (expect_it) begin
            tx_q.push_back(frame_of(d));
            if (loop) rx_q.push_back(d);
        end
        @(negedge CLK_I);
        WE_I = 1'b0;
    endtask

    task automatic inj_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < NBITS; i++) begin
            @(negedge CLK_I); inj = f[i];
            repeat (CPB - 1) @(negedge CLK_I);
        end
        @(negedge CLK_I); inj = 1'b1;
        repeat (CPB) @(negedge CLK_I);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rx_q.size() != 0 || tx_q.size() != 0 || TX_LEVEL_O != 0 || RX_VALID_O) && n < budget) begin
            @(negedge CLK_I); n++;
        end
        if (n >= budget) chk("drain_timeout", n, -1);
    endtask

    task automatic clr_pulse();
        @(negedge CLK_I); ERR_CLR_I = 1'b1;
        @(negedge CLK_I); ERR_CLR_I = 1'b0;
    endtask

    initial begin
        int n, lows;
        logic [7:0] d;
        bit exp_ovr;

        repeat (3) @(posedge CLK_I);
        @(negedge CLK_I); RST_I = 1'b0;
        chk("rst_tx_o", TX_O, 1);          chk("rst_rts", RTS_NO, 0);
        chk("rst_tx_ready", TX_READY_O, 1); chk("rst_rx_valid", RX_VALID_O, 0);
        chk("rst_tx_level", TX_LEVEL_O, 0); chk("rst_rx_level", RX_LEVEL_O, 0);
        chk("rst_flags", {PARITY_ERR_O, FRAME_ERR_O, OVERRUN_O}, 0);
        chk("rst_drec", DREC_O, 0);
        repeat (5) @(negedge CLK_I);

        // 0xA5 through the loop, start bit two edges after the write
        WE_I = 1'b1; DSEND_I = 8'hA5;
        tx_q.push_back(frame_of(8'hA5)); rx_q.push_back(8'hA5);
        n = 0;
        do begin @(posedge CLK_I); #1; n++; WE_I = 1'b0; end while (TX_O && n < 20);
        chk("tx_start_latency", n, 2);
        n = 0;
        while (!RX_VALID_O && n < 300) begin @(negedge CLK_I); n++; end
        chk("a5_drec", DREC_O, 8'hA5);
        chk("a5_level", RX_LEVEL_O, 1);
        chk("a5_flags", {PARITY_ERR_O, FRAME_ERR_O, OVERRUN_O}, 0);
        auto_read = 1;
        drain(500);

        // parity of 0x03 checked by the TX monitor, then random traffic
        send(8'h03, 1);
        for (int i = 0; i < 8; i++) send(8'($urandom_range(0, 255)), 1);
        drain(3000);

        // parity error, clear, and set-beats-clear
        loop = 1'b0;
        inj_frame(8'h07, 1'b0, 1'b1);
        chk("perr_set", PARITY_ERR_O, 1);
        chk("perr_level", RX_LEVEL_O, rx_q.size());
        chk("perr_no_ferr", FRAME_ERR_O, 0);
        clr_pulse();
        chk("perr_clear", PARITY_ERR_O, 0);
        ERR_CLR_I = 1'b1;
        fork
            inj_frame(8'h07, 1'b0, 1'b1);
            begin
                for (int k = 0; k < 200; k++) begin
                    @(negedge CLK_I);
                    if (PARITY_ERR_O) break;
                end
                ERR_CLR_I = 1'b0;
            end
        join
        repeat (3) @(negedge CLK_I);
        chk("perr_set_wins", PARITY_ERR_O, 1);
        clr_pulse();

        // frame error and glitch
        inj_frame(8'h55, 1'b0, 1'b0);
        chk("ferr_set", FRAME_ERR_O, 1);
        chk("ferr_level", RX_LEVEL_O, rx_q.size());
        chk("ferr_no_perr", PARITY_ERR_O, 0);
        clr_pulse();
        @(negedge CLK_I); inj = 1'b0;
        repeat (3) @(negedge CLK_I); inj = 1'b1;
        repeat (40) @(negedge CLK_I);
        chk("glitch_level", RX_LEVEL_O, rx_q.size());
        chk("glitch_flags", {PARITY_ERR_O, FRAME_ERR_O, OVERRUN_O}, 0);

        // overflow with RTS threshold 3
        auto_read = 0; trk_arm = 1; exp_ovr = 0;
        for (int k = 0; k < 5; k++) begin
            d = 8'($urandom_range(0, 255));
            if (rx_q.size() < DEPTH) rx_q.push_back(d);
            else exp_ovr = 1;
            inj_frame(d, ^d, 1'b1);
        end
        chk("ovr_level", RX_LEVEL_O, rx_q.size());
        chk("ovr_flag", OVERRUN_O, exp_ovr);
        chk("rts_high", RTS_NO, 1);
        chk("rts_delay", t_rts - t_lvl3, 1);
        trk_arm = 0;
        auto_read = 1;
        drain(200);
        clr_pulse();
        chk("ovr_clear", OVERRUN_O, 0);

        // CTS flow control
        loop = 1'b1;
        @(negedge CLK_I); CTS_NI = 1'b1;
        repeat (3) @(negedge CLK_I);
        send(8'h3C, 1); send(8'hC3, 1);
        lows = 0;
        repeat (60) begin @(negedge CLK_I); if (!TX_O) lows++; end
        chk("cts_hold", lows, 0);
        chk("cts_tx_level", TX_LEVEL_O, 2);
        @(negedge CLK_I); CTS_NI = 1'b0;
        n = 0;
        do begin @(posedge CLK_I); #1; n++; end while (TX_O && n < 20);
        chk("cts_start_latency", n, 3);
        repeat (30) @(negedge CLK_I); CTS_NI = 1'b1;
        repeat (150) @(negedge CLK_I);
        lows = 0;
        repeat (60) begin @(negedge CLK_I); if (!TX_O) lows++; end
        chk("cts_halt", lows, 0);
        chk("cts_halt_level", TX_LEVEL_O, 1);
        @(negedge CLK_I); CTS_NI = 1'b0;
        drain(1000);

        // reset in the middle of a TX data bit with RX partly full and a flag set
        loop = 1'b0; auto_read = 0;
        for (int k = 0; k < 3; k++) begin d = 8'($urandom_range(0, 255)); inj_frame(d, ^d, 1'b1); end
        inj_frame(8'h11, 1'b1, 1'b1);
        chk("pre_rst_rts", RTS_NO, 1);
        chk("pre_rst_perr", PARITY_ERR_O, 1);
        tx_mon_en = 0;
        send(8'h5A, 0);
        n = 0;
        while (TX_O && n < 50) begin @(negedge CLK_I); n++; end
        repeat (25) @(negedge CLK_I);
        RST_I = 1'b1;
        @(posedge CLK_I); #1;
        chk("rst_mid_tx_o", TX_O, 1);
        @(negedge CLK_I); RST_I = 1'b0;
        chk("rst_mid_levels", {TX_LEVEL_O, RX_LEVEL_O}, 0);
        chk("rst_mid_flags", {PARITY_ERR_O, FRAME_ERR_O, OVERRUN_O}, 0);
        chk("rst_mid_rts", RTS_NO, 0);
        repeat (5) @(negedge CLK_I);
        tx_mon_en = 1; loop = 1'b1; auto_read = 1;

        for (int i = 0; i < 4; i++) send(8'($urandom_range(0, 255)), 1);
        drain(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
